// File: rtl/gmii_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gmii_tx_arbiter_if                                                         |
// | Shared FIFO read port and word-count handshake toward the GMII TX block.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface gmii_tx_arbiter_if;
    logic [7:0]  tx_fifo_data;
    logic        tx_fifo_empty;
    logic        tx_fifo_rd;
    logic [10:0] word_count;
    logic        word_count_ready;
    logic        word_count_ack;
    logic        gmii_tx_en;

    modport master (
        output tx_fifo_data,
        output tx_fifo_empty,
        input  tx_fifo_rd,
        output word_count,
        output word_count_ready,
        input  word_count_ack,
        input  gmii_tx_en
    );

    modport slave (
        input  tx_fifo_data,
        input  tx_fifo_empty,
        output tx_fifo_rd,
        input  word_count,
        input  word_count_ready,
        output word_count_ack,
        output gmii_tx_en
    );
endinterface
`default_nettype wire

// File: rtl/gmii_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gmii_tx_arbiter                                                            |
// | Round-robin scheduler of two frame sources onto one GMII transmit block.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gmii_tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [10:0]           req0_len,
    output logic                  req0_grant,
    input  logic                  req1_valid,
    input  logic [10:0]           req1_len,
    output logic                  req1_grant,
    input  logic [7:0]            fifo0_data,
    input  logic                  fifo0_empty,
    output logic                  fifo0_rd,
    input  logic [7:0]            fifo1_data,
    input  logic                  fifo1_empty,
    output logic                  fifo1_rd,
    gmii_tx_arbiter_if.master     tx,
    output logic                  active_src,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int c_IFG_W = $clog2(IFG_CYCLES + 1);
    localparam int c_TO_W  = $clog2(START_TIMEOUT + 1);
    localparam logic [c_IFG_W-1:0] c_IFG_LOAD = c_IFG_W'(IFG_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(START_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_OFFER      = 3'd1;
    localparam logic [2:0] c_RELEASE    = 3'd2;
    localparam logic [2:0] c_WAIT_START = 3'd3;
    localparam logic [2:0] c_WAIT_END   = 3'd4;
    localparam logic [2:0] c_IFG        = 3'd5;

    logic [2:0]         r_state;
    logic [10:0]        r_word_count;
    logic               r_ready;
    logic               r_grant0;
    logic               r_grant1;
    logic               r_timeout;
    logic               r_active;
    logic               r_last;
    logic [c_IFG_W-1:0] r_ifg_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;

    logic w_any_req;
    logic w_win_src;
    logic w_path_on;

    // Under contention the source that did not win last time takes the grant.
    assign w_any_req = req0_valid | req1_valid;
    assign w_win_src = (req0_valid & req1_valid) ? ~r_last : req1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_word_count <= '0;
            r_ready      <= 1'b0;
            r_grant0     <= 1'b0;
            r_grant1     <= 1'b0;
            r_timeout    <= 1'b0;
            r_active     <= 1'b0;
            r_last       <= 1'b1;
            r_ifg_cnt    <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_grant0     <= ~w_win_src;
                        r_grant1     <= w_win_src;
                        r_active     <= w_win_src;
                        r_last       <= w_win_src;
                        r_word_count <= w_win_src ? req1_len : req0_len;
                        r_ready      <= 1'b1;
                        r_state      <= c_OFFER;
                    end
                end
                c_OFFER: begin
                    if (tx.word_count_ack) begin
                        r_ready <= 1'b0;
                        r_state <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    if (!tx.word_count_ack) begin
                        r_to_cnt <= '0;
                        r_state  <= c_WAIT_START;
                    end
                end
                c_WAIT_START: begin
                    if (tx.gmii_tx_en) begin
                        r_state <= c_WAIT_END;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= c_IFG;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                c_WAIT_END: begin
                    if (!tx.gmii_tx_en) begin
                        r_ifg_cnt <= c_IFG_LOAD;
                        r_state   <= c_IFG;
                    end
                end
                c_IFG: begin
                    if (r_ifg_cnt == '0) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt - c_IFG_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // The read path is gated off in IDLE so no source FIFO can be drained unowned.
    assign w_path_on        = (r_state != c_IDLE);
    assign tx.tx_fifo_data  = r_active ? fifo1_data : fifo0_data;
    assign tx.tx_fifo_empty = w_path_on ? (r_active ? fifo1_empty : fifo0_empty) : 1'b1;
    assign fifo0_rd         = w_path_on & ~r_active & tx.tx_fifo_rd;
    assign fifo1_rd         = w_path_on & r_active & tx.tx_fifo_rd;

    assign tx.word_count       = r_word_count;
    assign tx.word_count_ready = r_ready;
    assign req0_grant          = r_grant0;
    assign req1_grant          = r_grant1;
    assign active_src          = r_active;
    assign busy                = w_path_on;
    assign timeout_err         = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gmii_tx_arbiter                                                         |
// | Directed table-driven bench for gmii_tx_arbiter.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gmii_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [10:0] req0_len, req1_len;
    logic        req0_grant, req1_grant;
    logic [7:0]  fifo0_data, fifo1_data;
    logic        fifo0_empty, fifo1_empty;
    logic        fifo0_rd, fifo1_rd;
    logic        active_src, busy, timeout_err;

    gmii_tx_arbiter_if tif ();

    gmii_tx_arbiter #(
        .IFG_CYCLES    (12),
        .START_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_len    (req0_len),
        .req0_grant  (req0_grant),
        .req1_valid  (req1_valid),
        .req1_len    (req1_len),
        .req1_grant  (req1_grant),
        .fifo0_data  (fifo0_data),
        .fifo0_empty (fifo0_empty),
        .fifo0_rd    (fifo0_rd),
        .fifo1_data  (fifo1_data),
        .fifo1_empty (fifo1_empty),
        .fifo1_rd    (fifo1_rd),
        .tx          (tif),
        .active_src  (active_src),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       src;
        logic       rd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       e0;
        logic       e1;
        logic [7:0] exp_data;
        logic       exp_empty;
        logic       exp_rd0;
        logic       exp_rd1;
    } dp_vec_t;

    typedef struct {
        int          src;
        logic [10:0] len;
    } grant_vec_t;

    dp_vec_t    dp_tab [6];
    grant_vec_t gr_tab [4];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int src);
        src = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req0_grant || req1_grant) begin
                src = req1_grant ? 1 : 0;
                break;
            end
        end
        chk("grant_seen", (src >= 0) ? 1 : 0, 1);
        if (src >= 0) chk("grant_onehot", {req0_grant, req1_grant} == 2'b11 ? 1 : 0, 0);
    endtask

    // Offer stays stable for ack_delay cycles, then ack is raised and held.
    task automatic handshake(input int ack_delay, input int ack_hold, input logic [10:0] exp_len);
        chk("ready_at_grant", tif.word_count_ready, 1);
        chk("wc_at_grant", tif.word_count, exp_len);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            chk("ready_hold", tif.word_count_ready, 1);
            chk("wc_hold", tif.word_count, exp_len);
        end
        tif.word_count_ack = 1'b1;
        @(negedge clk);
        chk("ready_drop", tif.word_count_ready, 0);
        for (int i = 0; i < ack_hold; i++) begin
            @(negedge clk);
            chk("ready_stays_low", tif.word_count_ready, 0);
            chk("busy_in_release", busy, 1);
        end
        tif.word_count_ack = 1'b0;
    endtask

    // Drives a transmission of tx_cycles, exercising the datapath table for src.
    task automatic frame(input int src, input int tx_cycles, input bit check_ifg);
        int k;
        @(negedge clk);
        tif.gmii_tx_en = 1'b1;
        for (int i = 0; i < tx_cycles; i++) begin
            @(negedge clk);
            begin
                dp_vec_t v;
                v = dp_tab[src * 3 + (i % 3)];
                tif.tx_fifo_rd = v.rd;
                fifo0_data = v.d0;  fifo1_data = v.d1;
                fifo0_empty = v.e0; fifo1_empty = v.e1;
                #1;
                if (i < 6) begin
                    chk("dp_data", tif.tx_fifo_data, v.exp_data);
                    chk("dp_empty", tif.tx_fifo_empty, v.exp_empty);
                    chk("dp_rd0", fifo0_rd, v.exp_rd0);
                    chk("dp_rd1", fifo1_rd, v.exp_rd1);
                end
            end
        end
        chk("active_src", active_src, src);
        tif.gmii_tx_en = 1'b0;
        tif.tx_fifo_rd = 1'b0;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                k = i;
                break;
            end
        end
        if (check_ifg) chk("busy_drop_after_txen", k, 13);
        else chk("busy_drop_seen", (k > 0) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int src;
        int k;

        dp_tab[0] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        dp_tab[1] = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        dp_tab[2] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
        dp_tab[3] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
        dp_tab[4] = '{1'b1, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0};
        dp_tab[5] = '{1'b1, 1'b1, 8'h00, 8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1};
        gr_tab[0] = '{0, 11'd10};
        gr_tab[1] = '{1, 11'd20};
        gr_tab[2] = '{0, 11'd10};
        gr_tab[3] = '{1, 11'd20};

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_len = 0; req1_len = 0;
        fifo0_data = 8'h5A; fifo1_data = 8'hC3; fifo0_empty = 0; fifo1_empty = 0;
        tif.tx_fifo_rd = 1'b1; tif.word_count_ack = 0; tif.gmii_tx_en = 0;
        do_reset();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wc", tif.word_count, 0);
        chk("rst_ready", tif.word_count_ready, 0);
        chk("rst_grants", {req0_grant, req1_grant}, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_active", active_src, 0);
        chk("idle_empty", tif.tx_fifo_empty, 1);
        chk("idle_rd", {fifo0_rd, fifo1_rd}, 0);
        tif.tx_fifo_rd = 1'b0;

        // Single source, length 60, ack after 4 clocks, 70-clock frame.
        req0_valid = 1'b1; req0_len = 11'd60;
        wait_grant(src);
        chk("single_src", src, 0);
        req0_valid = 1'b0;
        handshake(4, 0, 11'd60);
        frame(0, 70, 1'b1);

        // Contention from a fresh reset: grants alternate 0,1,0,1.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_len = 11'd10; req1_len = 11'd20;
        for (int g = 0; g < 4; g++) begin
            wait_grant(src);
            chk("cont_src", src, gr_tab[g].src);
            chk("cont_len", tif.word_count, gr_tab[g].len);
            if (g == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            handshake(1, 0, gr_tab[g].len);
            frame(gr_tab[g].src, 6, 1'b1);
        end

        // Late length change, extended ack, tx_en pulse ignored in RELEASE, timeout.
        req1_valid = 1'b1; req1_len = 11'd100;
        wait_grant(src);
        chk("late_src", src, 1);
        req1_valid = 1'b0; req1_len = 11'd5;
        tif.word_count_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("late_wc", tif.word_count, 100);
        end
        tif.word_count_ack = 1'b1;
        @(negedge clk);
        chk("hs_ready_drop", tif.word_count_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tif.gmii_tx_en = (i == 1 || i == 2);
            @(negedge clk);
            chk("hs_ready_low", tif.word_count_ready, 0);
            chk("hs_busy", busy, 1);
        end
        tif.gmii_tx_en = 1'b0;
        tif.word_count_ack = 1'b0;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            chk("to_ready_low", tif.word_count_ready, 0);
            if (timeout_err) begin
                k = i;
                break;
            end
        end
        chk("timeout_clock", k, 65);
        @(negedge clk);
        chk("timeout_pulse", timeout_err, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grant(src);
        chk("after_timeout_src", src, 0);
        chk("after_timeout_wc", tif.word_count, 10);

        // Reset in WAIT_END with tx_en high; first grant afterwards goes to source 0.
        handshake(1, 0, 11'd10);
        @(negedge clk);
        tif.gmii_tx_en = 1'b1;
        tif.tx_fifo_rd = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", tif.word_count_ready, 0);
        chk("mid_rst_rd", {fifo0_rd, fifo1_rd}, 0);
        chk("mid_rst_grants", {req0_grant, req1_grant}, 0);
        @(negedge clk);
        rst = 1'b0;
        tif.gmii_tx_en = 1'b0;
        tif.tx_fifo_rd = 1'b0;
        wait_grant(src);
        chk("post_rst_src", src, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gmii_tx_arbiter.md
Name: gmii_tx_arbiter

Overview:
- Schedules transmission for the single GMII transmit interface block, which is driven by a FIFO plus a word-count handshake.
- Arbitrates round-robin between two frame sources. Each source has its own byte FIFO and frame-length request.
- Latches the winner's length and offers it over the word_count / word_count_ready / word_count_ack handshake.
- Steers the shared FIFO read port to the winner's FIFO, tracks the frame on gmii_tx_en, and enforces the inter-frame gap before the next grant.

Parameters:
IFG_CYCLES, 12, idle clocks enforced after gmii_tx_en falls before the next grant (minimum 1)
START_TIMEOUT, 64, max clocks to wait for gmii_tx_en rise after the handshake completes; on expiry the frame is abandoned

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  source 0 has a complete frame in fifo0
req0_len  input  11  source 0 word count, passed unchanged to word_count
req0_grant  output  1  one-cycle pulse: source 0 request accepted, len latched
req1_valid  input  1  source 1 request
req1_len  input  11  source 1 word count
req1_grant  output  1  one-cycle pulse for source 1
fifo0_data  input  8  source 0 FIFO read data
fifo0_empty  input  1  source 0 FIFO empty
fifo0_rd  output  1  source 0 FIFO read strobe
fifo1_data  input  8  source 1 FIFO read data
fifo1_empty  input  1  source 1 FIFO empty
fifo1_rd  output  1  source 1 FIFO read strobe
tx_fifo_data  output  8  to transmit interface fifo_data
tx_fifo_empty  output  1  to transmit interface fifo_empty
tx_fifo_rd  input  1  from transmit interface fifo_rd
word_count  output  11  latched length of the granted frame
word_count_ready  output  1  level; length offer valid
word_count_ack  input  1  from transmit interface (crosses its 3-stage synchroniser; arrives with latency)
gmii_tx_en  input  1  monitored transmit enable
active_src  output  1  source currently owning the FIFO path
busy  output  1  high in every state except IDLE
timeout_err  output  1  one-cycle pulse when START_TIMEOUT expires

Behaviour:
- Reset values (registered outputs): state=IDLE, word_count=0, word_count_ready=0, req0_grant=0, req1_grant=0, timeout_err=0, active_src=0, last_src=1 (source 0 wins first), ifg_cnt=0, to_cnt=0.
- Reset mid-operation returns to IDLE in one clock. No grant or ready is asserted in the reset cycle.
- Datapath mux is combinational on active_src:
  - tx_fifo_data and tx_fifo_empty come from the selected FIFO.
  - The selected fifoN_rd equals tx_fifo_rd; the other fifoN_rd is 0.
  - In IDLE, both fifoN_rd are 0 and tx_fifo_empty=1.
- IDLE:
  - If exactly one reqN_valid is set, that source wins.
  - If both are set, source !last_src wins.
  - On a win: pulse reqN_grant; set active_src and last_src; word_count<=reqN_len; word_count_ready<=1; go to OFFER.
- OFFER: hold word_count_ready=1 and word_count stable until word_count_ack=1, then word_count_ready<=0 and go to RELEASE.
- RELEASE: wait for word_count_ack=0, then clear to_cnt and go to WAIT_START.
- WAIT_START:
  - If gmii_tx_en=1, go to WAIT_END.
  - Otherwise increment to_cnt. At to_cnt==START_TIMEOUT-1, pulse timeout_err and go to IFG.
- WAIT_END: on gmii_tx_en=0, load ifg_cnt=IFG_CYCLES-1 and go to IFG.
- IFG: decrement ifg_cnt; at 0 go to IDLE. The earliest new grant is IFG_CYCLES+1 clocks after gmii_tx_en falls.
- active_src is held from grant through IFG; it is unchanged in IDLE.
- reqN_valid deasserting after grant has no effect. Changes to reqN_len after grant are ignored.
- Length 0 is passed through unchanged; no length checking.
- The counters are wide enough for their parameter values and never wrap.

Test Plan:
- Single source: req0_valid=1, len=60, ack returns 4 clocks after ready, tx_en high for 70 clocks -> one req0_grant pulse, word_count=60 held until ack, fifo0_rd mirrors tx_fifo_rd, fifo1_rd=0, busy drops exactly 13 clocks after tx_en falls.
- Contention: both valid continuously, lens 10 and 20 -> grants alternate 0,1,0,1; word_count alternates 10,20.
- Handshake: ack held high for 5 clocks after ready drops -> stays in RELEASE, no tx_en monitoring until ack=0, word_count_ready never re-asserts.
- Timeout: handshake completes, tx_en never rises -> timeout_err pulses at clock 64 of WAIT_START, IFG runs, next grant goes to the other source.
- Reset mid-frame: assert rst during WAIT_END with tx_en=1 -> next clock busy=0, ready=0, fifo rd strobes 0, and the first grant after reset goes to source 0.
- Late len change: req1_len changes from 100 to 5 one clock after grant -> word_count stays 100.
